// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port among NREQ cache requesters
//
// Ports:
//   CLK, RST             rising-edge clock, synchronous active-high reset
//   req_ren/req_wen      per-requester read/write request (NREQ bits)
//   req_addr/req_store   per-requester word address / write data, slice i = [32*i+31:32*i]
//   req_wait             1 = requester holds, 0 = access finished this cycle
//   req_load             read data for the requester whose req_wait is 0
//   req_err              1-cycle error/timeout pulse alongside the wait release
//   ramREN/ramWEN        RAM read/write enables
//   ramaddr/ramstore     RAM address / write data
//   ramload/ramstate     RAM read data / status (FREE=0, BUSY=1, ACCESS=2, ERROR=3)
module ram_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req_ren,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_store,
    output logic [NREQ-1:0]      req_wait,
    output logic [31:0]          req_load,
    output logic [NREQ-1:0]      req_err,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q;
    logic [TW-1:0]   tcount_q;

    logic [NREQ-1:0] active;
    logic            any_active;
    logic            g_active;
    logic            timeout;
    logic            done;
    logic            err_end;

    assign active     = req_ren | req_wen;
    assign any_active = |active;
    assign g_active   = active[grant_q];
    assign timeout    = (tcount_q == TW'(TIMEOUT - 1));

    // An abort (granted requester drops both enables) takes priority over
    // any RAM completion arriving in the same cycle.
    assign done    = (state_q == GRANT) && g_active &&
                     ((ramstate == RS_ACCESS) || (ramstate == RS_ERROR) || timeout);
    assign err_end = done && (ramstate != RS_ACCESS);

    // Round-robin pick: first active index after the last one served.
    always_comb begin
        logic found;
        grant_d = grant_q;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && active[(int'(last_q) + k) % NREQ]) begin
                found   = 1'b1;
                grant_d = IW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // RAM side and requester side are driven combinationally so a same-cycle
    // ACCESS completes with single-cycle latency. A pending reset suppresses
    // the release so a killed access never looks completed.
    always_comb begin
        req_wait = '1;
        req_err  = '0;
        req_load = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (state_q == GRANT) begin
            ramaddr  = req_addr[32*int'(grant_q) +: 32];
            ramstore = req_store[32*int'(grant_q) +: 32];
            ramWEN   = req_wen[grant_q];
            ramREN   = req_ren[grant_q] & ~req_wen[grant_q];
            if (done && !RST) begin
                req_wait[grant_q] = 1'b0;
                if (err_end) begin
                    req_err[grant_q] = 1'b1;
                end else begin
                    req_load = ramload;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IW'(NREQ - 1);
            tcount_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_active) begin
                        grant_q  <= grant_d;
                        tcount_q <= '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!g_active || done) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end else if (tcount_q != '1) begin
                        tcount_q <= tcount_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed table-driven bench for ram_arbiter
module tb_ram_arbiter;

    logic         CLK = 1'b0;
    logic         RST;
    logic [3:0]   req_ren, req_wen;
    logic [127:0] req_addr, req_store;
    logic [3:0]   req_wait, req_err;
    logic [31:0]  req_load;
    logic         ramREN, ramWEN;
    logic [31:0]  ramaddr, ramstore, ramload;
    logic [1:0]   ramstate;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST),
        .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store),
        .req_wait(req_wait), .req_load(req_load), .req_err(req_err),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct {
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [3:0]  ew;
        logic [3:0]  ee;
        logic        eren;
        logic        ewen;
        logic        chka;
        logic [31:0] eaddr;
        logic [31:0] estore;
        logic [31:0] eload;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic [3:0] ren, logic [3:0] wen, logic [1:0] rs, logic [31:0] rl,
                                logic [3:0] ew, logic [3:0] ee, logic eren, logic ewen, logic chka,
                                logic [31:0] eaddr, logic [31:0] estore, logic [31:0] eload);
        vec_t v;
        v.ren = ren; v.wen = wen; v.rs = rs; v.rl = rl; v.ew = ew; v.ee = ee;
        v.eren = eren; v.ewen = ewen; v.chka = chka;
        v.eaddr = eaddr; v.estore = estore; v.eload = eload;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " wait"}, {28'd0, req_wait}, 32'hF);
        chk({name, " err"}, {28'd0, req_err}, 32'h0);
        chk({name, " en"}, {30'd0, ramREN, ramWEN}, 32'h0);
        chk({name, " addr"}, ramaddr, 32'h0);
        chk({name, " load"}, req_load, 32'h0);
    endtask

    initial begin
        RST       = 1'b1;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = {32'h30, 32'h80, 32'h40, 32'h10};
        req_store = {32'h0, 32'h1234, 32'h0, 32'h0};
        ramload   = '0;
        ramstate  = 2'd0;

        // Table: one row per cycle, inputs applied at negedge, outputs checked 1 time unit later.
        //            ren    wen    rs     rl             ew     ee     REN   WEN   chka  addr    store     load
        tbl[0]  = mk(4'h2, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[1]  = mk(4'h2, 4'h0, 2'd1, 32'h0,         4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0,    32'h0);
        tbl[2]  = mk(4'h2, 4'h0, 2'd1, 32'h0,         4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0,    32'h0);
        tbl[3]  = mk(4'h2, 4'h0, 2'd1, 32'h0,         4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0,    32'h0);
        tbl[4]  = mk(4'h2, 4'h0, 2'd2, 32'hDEADBEEF,  4'hD, 4'h0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0,    32'hDEADBEEF);
        tbl[5]  = mk(4'h0, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[6]  = mk(4'h4, 4'h4, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[7]  = mk(4'h4, 4'h4, 2'd2, 32'h0,         4'hB, 4'h0, 1'b0, 1'b1, 1'b1, 32'h80, 32'h1234, 32'h0);
        tbl[8]  = mk(4'h0, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[9]  = mk(4'h1, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[10] = mk(4'h1, 4'h0, 2'd3, 32'h5555,      4'hE, 4'h1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0,    32'h0);
        tbl[11] = mk(4'h0, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[12] = mk(4'h8, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);
        tbl[13] = mk(4'h8, 4'h0, 2'd1, 32'h0,         4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 32'h30, 32'h0,    32'h0);
        tbl[14] = mk(4'h0, 4'h0, 2'd2, 32'h77,        4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'h0);
        tbl[15] = mk(4'h0, 4'h0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h0,    32'h0);

        // Reset, then 10 idle cycles
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1 chk_idle("reset_idle");
            @(negedge CLK);
        end

        // Directed table: read with BUSY, write-wins, ERROR, abort
        for (int i = 0; i < 16; i++) begin
            req_ren  = tbl[i].ren;
            req_wen  = tbl[i].wen;
            ramstate = tbl[i].rs;
            ramload  = tbl[i].rl;
            #1;
            chk($sformatf("tbl%0d wait", i), {28'd0, req_wait}, {28'd0, tbl[i].ew});
            chk($sformatf("tbl%0d err", i), {28'd0, req_err}, {28'd0, tbl[i].ee});
            chk($sformatf("tbl%0d en", i), {30'd0, ramREN, ramWEN}, {30'd0, tbl[i].eren, tbl[i].ewen});
            chk($sformatf("tbl%0d load", i), req_load, tbl[i].eload);
            if (tbl[i].chka) begin
                chk($sformatf("tbl%0d addr", i), ramaddr, tbl[i].eaddr);
                chk($sformatf("tbl%0d store", i), ramstore, tbl[i].estore);
            end
            @(negedge CLK);
        end

        // Timeout: RAM stuck BUSY, release with error in the 64th GRANT cycle
        req_ren  = 4'h2;
        ramstate = 2'd1;
        #1 chk_idle("to_idle");
        @(negedge CLK);
        for (int c = 1; c <= 64; c++) begin
            #1;
            if (c < 64) begin
                chk($sformatf("to_hold%0d", c), {28'd0, req_wait, req_err}, {28'd0, 4'hF, 4'h0});
            end else begin
                chk("to_release wait", {28'd0, req_wait}, 32'hD);
                chk("to_release err", {28'd0, req_err}, 32'h2);
            end
            @(negedge CLK);
        end
        req_ren = 4'h0;
        #1 chk_idle("to_after");
        @(negedge CLK);

        // ERROR gives the same result in the first GRANT cycle
        req_ren = 4'h2;
        #1 chk_idle("err_idle");
        @(negedge CLK);
        ramstate = 2'd3;
        #1;
        chk("err_now wait", {28'd0, req_wait}, 32'hD);
        chk("err_now err", {28'd0, req_err}, 32'h2);
        @(negedge CLK);
        req_ren  = 4'h0;
        ramstate = 2'd0;
        #1 chk_idle("err_after");
        @(negedge CLK);

        // Reset mid-GRANT with ACCESS: no release; then round robin restarts at 0
        req_ren  = 4'h4;
        ramstate = 2'd1;
        #1 chk_idle("rst_idle");
        @(negedge CLK);
        #1 chk("rst_grant ren", {31'd0, ramREN}, 32'h1);
        chk("rst_grant addr", ramaddr, 32'h80);
        @(negedge CLK);
        RST      = 1'b1;
        ramstate = 2'd2;
        #1;
        chk("rst_access wait", {28'd0, req_wait}, 32'hF);
        chk("rst_access err", {28'd0, req_err}, 32'h0);
        @(negedge CLK);
        RST     = 1'b0;
        req_ren = 4'hF;
        #1 chk_idle("rst_after");
        @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_w;
            logic [127:0] addrs;
            exp_w = ~(4'b0001 << (k % 4));
            addrs = req_addr;
            #1;
            chk($sformatf("rr%0d wait", k), {28'd0, req_wait}, {28'd0, exp_w});
            chk($sformatf("rr%0d addr", k), ramaddr, addrs[32*(k%4) +: 32]);
            @(negedge CLK);
            #1 chk($sformatf("rr%0d gap", k), {28'd0, req_wait}, 32'hF);
            @(negedge CLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
